// File: rtl/ad9434_deframer.sv
// rtl/ad9434_deframer.sv - AD9434 half-word deframer: marker lock, sample rebuild, error and peak stats
//
// Ports:
//   clk, rst_n         capture-stage clock, asynchronous active-low reset
//   en                 deframer enable; low forces SEARCH and drops any half-assembled sample
//   in_word[6:0]       captured word: [6] = marker (1 = MSB half), [5:0] = half-sample
//   err_clr            synchronous clear of err_count
//   peak_clr           synchronous clear of peak_abs
//   sample_out[11:0]   two's-complement sample, qualified by sample_valid
//   sample_valid       one-cycle strobe per rebuilt sample
//   sample_ovr         sample is at full scale (-2048 or +2047), qualifies sample_valid
//   locked             high while in LOCKED
//   err_count[15:0]    saturating count of marker mismatches seen while locked
//   peak_abs[11:0]     largest |sample| since the last clear
module ad9434_deframer #(
  parameter int unsigned LOCK_COUNT = 16,
  parameter int unsigned ERR_LIMIT  = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [6:0]  in_word,
  input  logic        err_clr,
  input  logic        peak_clr,
  output logic [11:0] sample_out,
  output logic        sample_valid,
  output logic        sample_ovr,
  output logic        locked,
  output logic [15:0] err_count,
  output logic [11:0] peak_abs
);

  typedef enum logic {SEARCH, LOCKED} state_t;

  // Counters compare against the value just before the limit so the
  // transition lands on the edge that registers the limit-th event.
  localparam logic [7:0] LOCK_LAST = 8'(LOCK_COUNT - 1);
  localparam logic [7:0] ERR_LAST  = 8'(ERR_LIMIT - 1);

  state_t      state_q, state_d;
  logic [6:0]  r0_q;
  logic        m1_q;
  logic [7:0]  good_cnt_q, good_cnt_d;
  logic [7:0]  err_run_q, err_run_d;
  logic        have_msb_q, have_msb_d;
  logic [5:0]  msb_hold_q, msb_hold_d;
  logic [11:0] sample_q, sample_d;
  logic        valid_q, valid_d;
  logic        ovr_q, ovr_d;
  logic [15:0] err_cnt_q, err_cnt_d;
  logic [11:0] peak_q, peak_d;

  logic        match;
  logic        emit;
  logic        counted;
  logic [11:0] raw;
  logic [11:0] conv;
  logic [11:0] mag;

  assign match = r0_q[6] ^ m1_q;
  assign raw   = {msb_hold_q, r0_q[5:0]};
  assign conv  = {~raw[11], raw[10:0]};
  // Negating -2048 in 12 bits yields 0x800, which read unsigned is 2048.
  assign mag   = conv[11] ? (~conv + 12'd1) : conv;

  always_comb begin
    state_d    = state_q;
    good_cnt_d = good_cnt_q;
    err_run_d  = err_run_q;
    have_msb_d = have_msb_q;
    msb_hold_d = msb_hold_q;
    emit       = 1'b0;
    counted    = 1'b0;

    if (!en) begin
      state_d    = SEARCH;
      good_cnt_d = '0;
      err_run_d  = '0;
      have_msb_d = 1'b0;
    end else begin
      case (state_q)
        SEARCH: begin
          if (match) begin
            if (good_cnt_q == LOCK_LAST) begin
              state_d    = LOCKED;
              good_cnt_d = '0;
              err_run_d  = '0;
            end else begin
              good_cnt_d = good_cnt_q + 8'd1;
            end
          end else begin
            good_cnt_d = '0;
          end
        end
        LOCKED: begin
          if (match) begin
            err_run_d = '0;
            if (r0_q[6]) begin
              msb_hold_d = r0_q[5:0];
              have_msb_d = 1'b1;
            end else if (have_msb_q) begin
              emit       = 1'b1;
              have_msb_d = 1'b0;
            end
          end else begin
            // A broken pair is dropped rather than emitted with a stale MSB.
            counted    = 1'b1;
            have_msb_d = 1'b0;
            err_run_d  = err_run_q + 8'd1;
            if (err_run_q == ERR_LAST) begin
              state_d    = SEARCH;
              good_cnt_d = '0;
            end
          end
        end
        default: state_d = SEARCH;
      endcase
    end

    valid_d  = emit;
    ovr_d    = emit && ((raw == 12'h000) || (raw == 12'hFFF));
    sample_d = emit ? conv : sample_q;

    err_cnt_d = err_cnt_q;
    if (err_clr) begin
      err_cnt_d = counted ? 16'd1 : 16'd0;
    end else if (counted && (err_cnt_q != 16'hFFFF)) begin
      err_cnt_d = err_cnt_q + 16'd1;
    end

    peak_d = peak_q;
    if (emit) begin
      peak_d = (peak_clr || (mag > peak_q)) ? mag : peak_q;
    end else if (peak_clr) begin
      peak_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= SEARCH;
      r0_q       <= '0;
      m1_q       <= 1'b0;
      good_cnt_q <= '0;
      err_run_q  <= '0;
      have_msb_q <= 1'b0;
      msb_hold_q <= '0;
      sample_q   <= '0;
      valid_q    <= 1'b0;
      ovr_q      <= 1'b0;
      err_cnt_q  <= '0;
      peak_q     <= '0;
    end else begin
      state_q    <= state_d;
      r0_q       <= in_word;
      m1_q       <= r0_q[6];
      good_cnt_q <= good_cnt_d;
      err_run_q  <= err_run_d;
      have_msb_q <= have_msb_d;
      msb_hold_q <= msb_hold_d;
      sample_q   <= sample_d;
      valid_q    <= valid_d;
      ovr_q      <= ovr_d;
      err_cnt_q  <= err_cnt_d;
      peak_q     <= peak_d;
    end
  end

  assign sample_out   = sample_q;
  assign sample_valid = valid_q;
  assign sample_ovr   = ovr_q;
  assign locked       = (state_q == LOCKED);
  assign err_count    = err_cnt_q;
  assign peak_abs     = peak_q;

endmodule

// File: tb/tb_ad9434_deframer.sv
// tb/tb_ad9434_deframer.sv - self-checking bench for ad9434_deframer against a behavioural model
module tb_ad9434_deframer;

  localparam int LOCK_COUNT = 16;
  localparam int ERR_LIMIT  = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        err_clr = 1'b0;
  logic        peak_clr = 1'b0;
  logic [6:0]  in_word = 7'h00;
  logic [11:0] sample_out, peak_abs;
  logic        sample_valid, sample_ovr, locked;
  logic [15:0] err_count;
  logic [11:0] s_sample, s_peak;
  logic        s_valid, s_ovr, s_locked;
  logic [15:0] s_err;

  int checks = 0;
  int errors = 0;

  // Model: word and marker history, alternation/miss runs, pending MSB half (-1 = none).
  int m_r0, m_m1, alt_seen, miss_seen, half;
  bit m_locked;
  bit exp_valid, exp_ovr;
  int exp_out, exp_err, exp_peak;

  ad9434_deframer #(.LOCK_COUNT(LOCK_COUNT), .ERR_LIMIT(ERR_LIMIT)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .in_word(in_word), .err_clr(err_clr), .peak_clr(peak_clr),
    .sample_out(sample_out), .sample_valid(sample_valid), .sample_ovr(sample_ovr),
    .locked(locked), .err_count(err_count), .peak_abs(peak_abs)
  );

  ad9434_deframer #(.LOCK_COUNT(16), .ERR_LIMIT(255)) u_sat (
    .clk(clk), .rst_n(rst_n), .en(en), .in_word(in_word), .err_clr(err_clr), .peak_clr(peak_clr),
    .sample_out(s_sample), .sample_valid(s_valid), .sample_ovr(s_ovr),
    .locked(s_locked), .err_count(s_err), .peak_abs(s_peak)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    m_r0 = 0; m_m1 = 0; alt_seen = 0; miss_seen = 0; half = -1; m_locked = 0;
    exp_valid = 0; exp_ovr = 0; exp_out = 0; exp_err = 0; exp_peak = 0;
  endfunction

  function automatic void model_edge(input int w, input bit e, input bit ec, input bit pc);
    bit is_alt, emit, counted;
    int val, mag;
    is_alt = (((m_r0 >> 6) & 1) != m_m1);
    emit = 0; counted = 0; val = 0;
    if (!e) begin
      m_locked = 0; alt_seen = 0; miss_seen = 0; half = -1;
    end else if (!m_locked) begin
      alt_seen = is_alt ? alt_seen + 1 : 0;
      if (alt_seen == LOCK_COUNT) begin m_locked = 1; alt_seen = 0; miss_seen = 0; end
    end else if (is_alt) begin
      miss_seen = 0;
      if ((m_r0 & 64) != 0) half = m_r0 & 63;
      else if (half >= 0) begin
        emit = 1; val = half * 64 + (m_r0 & 63) - 2048; half = -1;
      end
    end else begin
      counted = 1; half = -1; miss_seen++;
      if (miss_seen == ERR_LIMIT) begin m_locked = 0; alt_seen = 0; end
    end
    exp_valid = emit;
    exp_ovr = emit && (val == -2048 || val == 2047);
    if (emit) exp_out = val & 'hFFF;
    if (ec) exp_err = counted ? 1 : 0;
    else if (counted && exp_err < 65535) exp_err++;
    mag = (val < 0) ? -val : val;
    if (emit) exp_peak = (pc || mag > exp_peak) ? mag : exp_peak;
    else if (pc) exp_peak = 0;
    m_m1 = (m_r0 >> 6) & 1;
    m_r0 = w;
  endfunction

  task automatic step(input logic [6:0] w, input bit e, input bit ec, input bit pc);
    in_word = w; en = e; err_clr = ec; peak_clr = pc;
    @(posedge clk);
    model_edge(int'(w), e, ec, pc);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    model_reset();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1; in_word = 7'h55;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (sample_out !== 12'h000) begin errors++; $display("FAIL reset_sample got %h exp 000", sample_out); end
    checks++; if (sample_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", sample_valid); end
    checks++; if (sample_ovr !== 1'b0) begin errors++; $display("FAIL reset_ovr got %b exp 0", sample_ovr); end
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL reset_locked got %b exp 0", locked); end
    checks++; if (err_count !== 16'h0000) begin errors++; $display("FAIL reset_err got %h exp 0000", err_count); end
    checks++; if (peak_abs !== 12'h000) begin errors++; $display("FAIL reset_peak got %h exp 000", peak_abs); end
    model_reset();
    rst_n = 1'b1;
  endtask

  task automatic test_lock();
    int rise, first_v, nvalid;
    bit prev_v;
    rise = -1; first_v = -1; nvalid = 0; prev_v = 0;
    for (int i = 0; i < 40; i++) begin
      step((i % 2 == 0) ? 7'h60 : 7'h00, 1, 0, 0);
      checks++; if (locked !== m_locked) begin errors++; $display("FAIL lock_track edge %0d got %b exp %b", i + 1, locked, m_locked); end
      if (locked === 1'b1 && rise < 0) rise = i + 1;
      if (sample_valid === 1'b1) begin
        nvalid++;
        if (prev_v) begin checks++; errors++; $display("FAIL lock_back_to_back edge %0d valid on consecutive cycles", i + 1); end
        if (first_v < 0) begin
          first_v = i + 1;
          checks++; if (sample_out !== 12'h000) begin errors++; $display("FAIL lock_first_sample got %h exp 000", sample_out); end
          checks++; if (sample_ovr !== 1'b0) begin errors++; $display("FAIL lock_first_ovr got %b exp 0", sample_ovr); end
        end
      end
      prev_v = sample_valid;
    end
    checks++; if (rise != LOCK_COUNT + 1) begin errors++; $display("FAIL lock_rise_edge got %0d exp %0d", rise, LOCK_COUNT + 1); end
    checks++; if (first_v != LOCK_COUNT + 3) begin errors++; $display("FAIL lock_first_valid_edge got %0d exp %0d", first_v, LOCK_COUNT + 3); end
    checks++; if (nvalid != 11) begin errors++; $display("FAIL lock_valid_count got %0d exp 11", nvalid); end
  endtask

  task automatic test_fullscale();
    step(7'h7F, 1, 0, 0);
    step(7'h3F, 1, 0, 0);
    step(7'h40, 1, 0, 0);
    checks++; if (sample_valid !== 1'b1) begin errors++; $display("FAIL fs_pos_valid got %b exp 1", sample_valid); end
    checks++; if (sample_out !== 12'h7FF) begin errors++; $display("FAIL fs_pos_sample got %h exp 7ff", sample_out); end
    checks++; if (sample_ovr !== 1'b1) begin errors++; $display("FAIL fs_pos_ovr got %b exp 1", sample_ovr); end
    checks++; if (peak_abs !== 12'd2047) begin errors++; $display("FAIL fs_pos_peak got %0d exp 2047", peak_abs); end
    step(7'h00, 1, 0, 0);
    step(7'h60, 1, 0, 0);
    checks++; if (sample_out !== 12'h800) begin errors++; $display("FAIL fs_neg_sample got %h exp 800", sample_out); end
    checks++; if (sample_ovr !== 1'b1) begin errors++; $display("FAIL fs_neg_ovr got %b exp 1", sample_ovr); end
    checks++; if (peak_abs !== 12'd2048) begin errors++; $display("FAIL fs_neg_peak got %0d exp 2048", peak_abs); end
    step(7'h00, 1, 0, 0);
  endtask

  task automatic test_glitch();
    step(7'h11, 1, 0, 0);
    step(7'h12, 1, 0, 0);
    checks++; if (sample_valid !== 1'b0) begin errors++; $display("FAIL glitch_valid1 got %b exp 0", sample_valid); end
    step(7'h13, 1, 0, 0);
    checks++; if (sample_valid !== 1'b0) begin errors++; $display("FAIL glitch_valid2 got %b exp 0", sample_valid); end
    step(7'h60, 1, 0, 0);
    checks++; if (sample_valid !== 1'b0) begin errors++; $display("FAIL glitch_valid3 got %b exp 0", sample_valid); end
    checks++; if (err_count !== 16'd3) begin errors++; $display("FAIL glitch_err got %0d exp 3", err_count); end
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL glitch_locked got %b exp 1", locked); end
    step(7'h04, 1, 0, 0);
    step(7'h45, 1, 0, 0);
    checks++; if (sample_valid !== 1'b1 || sample_out !== 12'h004) begin errors++; $display("FAIL glitch_resume got v=%b s=%h exp v=1 s=004", sample_valid, sample_out); end
    step(7'h46, 1, 0, 0);
    step(7'h07, 1, 1, 0);
    checks++; if (err_count !== 16'd1) begin errors++; $display("FAIL errclr_coincident got %0d exp 1", err_count); end
    step(7'h48, 1, 0, 0);
    checks++; if (sample_valid !== 1'b0) begin errors++; $display("FAIL glitch_broken_pair got %b exp 0", sample_valid); end
    checks++; if (err_count !== 16'(exp_err)) begin errors++; $display("FAIL glitch_err_model got %0d exp %0d", err_count, exp_err); end
  endtask

  task automatic test_lose_lock();
    step(7'h49, 1, 0, 0);
    for (int k = 0; k < 4; k++) begin
      step(7'h4A + 7'(k), 1, 0, 0);
      checks++; if (locked !== (k < 3)) begin errors++; $display("FAIL loss_locked mismatch %0d got %b exp %b", k + 1, locked, (k < 3)); end
    end
    checks++; if (err_count !== 16'd5) begin errors++; $display("FAIL loss_err got %0d exp 5", err_count); end
    for (int j = 0; j < 24; j++) begin
      step({(j % 2 == 1), 6'($urandom)}, 1, 0, 0);
      checks++; if (locked !== (j >= 16)) begin errors++; $display("FAIL relock_locked step %0d got %b exp %b", j, locked, (j >= 16)); end
      if (j < 19) begin
        checks++; if (sample_valid !== 1'b0) begin errors++; $display("FAIL relock_valid step %0d got 1 exp 0", j); end
      end else begin
        checks++; if (sample_valid !== exp_valid) begin errors++; $display("FAIL relock_valid_model step %0d got %b exp %b", j, sample_valid, exp_valid); end
      end
    end
  endtask

  task automatic test_enable_peak();
    step(7'h10, 0, 0, 0);
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL en_locked got %b exp 0", locked); end
    checks++; if (peak_abs !== 12'd2048) begin errors++; $display("FAIL en_peak_hold got %0d exp 2048", peak_abs); end
    for (int k = 0; k < 5; k++) begin
      step(7'h10, 0, 0, 0);
      checks++; if (sample_valid !== 1'b0 || locked !== 1'b0) begin errors++; $display("FAIL en_low step %0d got v=%b l=%b exp 0 0", k, sample_valid, locked); end
    end
    for (int j = 0; j < 20; j++) step({(j % 2 == 0), 6'($urandom)}, 1, 0, 0);
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL en_relock got %b exp 1", locked); end
    step(7'h5F, 1, 0, 0);
    step(7'h3B, 1, 0, 1);
    checks++; if (peak_abs !== 12'd0) begin errors++; $display("FAIL peakclr_alone got %0d exp 0", peak_abs); end
    step(7'h60, 1, 0, 1);
    checks++; if (sample_valid !== 1'b1 || sample_out !== 12'hFFB) begin errors++; $display("FAIL neg5_sample got v=%b s=%h exp v=1 s=ffb", sample_valid, sample_out); end
    checks++; if (peak_abs !== 12'd5) begin errors++; $display("FAIL peakclr_with_sample got %0d exp 5", peak_abs); end
  endtask

  task automatic test_rst_midpair();
    #2 rst_n = 1'b0;
    #1;
    checks++; if (sample_out !== 12'h000 || sample_valid !== 1'b0 || sample_ovr !== 1'b0) begin errors++; $display("FAIL rst_async_sample got s=%h v=%b o=%b exp 000 0 0", sample_out, sample_valid, sample_ovr); end
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL rst_async_locked got %b exp 0", locked); end
    checks++; if (err_count !== 16'h0 || peak_abs !== 12'h0) begin errors++; $display("FAIL rst_async_stats got e=%0d p=%0d exp 0 0", err_count, peak_abs); end
    @(posedge clk);
    #1;
    model_reset();
    rst_n = 1'b1;
    for (int j = 0; j < LOCK_COUNT + 1; j++) begin
      step({(j % 2 == 0), 6'($urandom)}, 1, 0, 0);
      if (j == LOCK_COUNT - 1) begin
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL rst_relock_early got %b exp 0", locked); end
      end
    end
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL rst_relock got %b exp 1", locked); end
  endtask

  task automatic test_random();
    bit mk, e, ec, pc;
    logic [5:0] d;
    mk = in_word[6];
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 99) >= 5) mk = ~mk;
      e  = ($urandom_range(0, 99) >= 2);
      ec = ($urandom_range(0, 99) < 3);
      pc = ($urandom_range(0, 99) < 3);
      d  = ($urandom_range(0, 9) == 0) ? ($urandom_range(0, 1) ? 6'h3F : 6'h00) : 6'($urandom);
      step({mk, d}, e, ec, pc);
      checks++; if (sample_valid !== exp_valid) begin errors++; $display("FAIL rnd_valid cyc %0d got %b exp %b", i, sample_valid, exp_valid); end
      if (exp_valid) begin
        checks++; if (sample_out !== 12'(exp_out) || sample_ovr !== exp_ovr) begin errors++; $display("FAIL rnd_sample cyc %0d got %h/%b exp %h/%b", i, sample_out, sample_ovr, 12'(exp_out), exp_ovr); end
      end
      checks++; if (locked !== m_locked) begin errors++; $display("FAIL rnd_locked cyc %0d got %b exp %b", i, locked, m_locked); end
      checks++; if (err_count !== 16'(exp_err)) begin errors++; $display("FAIL rnd_err cyc %0d got %0d exp %0d", i, err_count, exp_err); end
      checks++; if (peak_abs !== 12'(exp_peak)) begin errors++; $display("FAIL rnd_peak cyc %0d got %0d exp %0d", i, peak_abs, exp_peak); end
    end
  endtask

  task automatic test_saturation();
    bit mk;
    do_reset();
    for (int j = 0; j < 20; j++) step({(j % 2 == 0), 6'($urandom)}, 1, 0, 0);
    checks++; if (s_locked !== 1'b1) begin errors++; $display("FAIL sat_lock got %b exp 1", s_locked); end
    mk = 1'b0;
    for (int b = 0; b < 259; b++) begin
      for (int k = 0; k < 254; k++) step({mk, 6'($urandom)}, 1, 0, 0);
      mk = ~mk;
      step({mk, 6'($urandom)}, 1, 0, 0);
    end
    checks++; if (s_err !== 16'hFFFF) begin errors++; $display("FAIL sat_reach got %h exp ffff", s_err); end
    for (int k = 0; k < 8; k++) step({mk, 6'($urandom)}, 1, 0, 0);
    checks++; if (s_err !== 16'hFFFF || s_locked !== 1'b1) begin errors++; $display("FAIL sat_hold got %h l=%b exp ffff l=1", s_err, s_locked); end
    step({mk, 6'($urandom)}, 1, 1, 0);
    checks++; if (s_err !== 16'd1) begin errors++; $display("FAIL sat_errclr got %0d exp 1", s_err); end
    checks++; if (err_count !== 16'(exp_err)) begin errors++; $display("FAIL sat_main_err got %0d exp %0d", err_count, exp_err); end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_lock();
    test_fullscale();
    test_glitch();
    test_lose_lock();
    test_enable_peak();
    test_rst_midpair();
    test_random();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
